// File: rtl/div_pkg.sv
// Shared types and constants for the radix-2 restoring divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, PREP, CALC, DONE} div_state_e;

  localparam int DIV_W    = 32;
  localparam int DIV_ITER = 32;
  localparam logic [DIV_W-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

  // {remainder, quotient} with each half negated on its own sign flag.
  function automatic logic [2*DIV_W-1:0] apply_sign(input logic [2*DIV_W-1:0] sr,
                                                    input logic sign_q, input logic sign_r);
    logic [DIV_W-1:0] q, r;
    q = sign_q ? -sr[DIV_W-1:0] : sr[DIV_W-1:0];
    r = sign_r ? -sr[2*DIV_W-1:DIV_W] : sr[2*DIV_W-1:DIV_W];
    return {r, q};
  endfunction

endpackage

// File: rtl/div_if.sv
// Operand and result stream channels of the divider.
interface div_if;
  import div_pkg::*;

  logic [DIV_W-1:0]   s_axis_dividend_tdata;
  logic               s_axis_dividend_tvalid;
  logic               s_axis_dividend_tready;
  logic [DIV_W-1:0]   s_axis_divisor_tdata;
  logic               s_axis_divisor_tvalid;
  logic               s_axis_divisor_tready;
  logic [2*DIV_W-1:0] m_axis_dout_tdata;
  logic               m_axis_dout_tvalid;
  logic               m_axis_dout_tready;

  modport master (
    output s_axis_dividend_tdata, s_axis_dividend_tvalid,
    output s_axis_divisor_tdata, s_axis_divisor_tvalid,
    output m_axis_dout_tready,
    input  s_axis_dividend_tready, s_axis_divisor_tready,
    input  m_axis_dout_tdata, m_axis_dout_tvalid
  );

  modport slave (
    input  s_axis_dividend_tdata, s_axis_dividend_tvalid,
    input  s_axis_divisor_tdata, s_axis_divisor_tvalid,
    input  m_axis_dout_tready,
    output s_axis_dividend_tready, s_axis_divisor_tready,
    output m_axis_dout_tdata, m_axis_dout_tvalid
  );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration on the {rem, quo} shift register.
module div_step
  import div_pkg::*;
(
  input  logic [2*DIV_W-1:0] sr,
  input  logic [DIV_W-1:0]   dvs,
  output logic [2*DIV_W-1:0] sr_nxt
);
  logic [DIV_W:0]   rem_sh;
  logic             ge;
  logic [DIV_W-1:0] diff;

  // rem_sh is the remainder after the left shift; it is below 2*dvs, so a
  // successful trial difference always fits in DIV_W bits.
  assign rem_sh = sr[2*DIV_W-1:DIV_W-1];
  assign ge     = rem_sh >= {1'b0, dvs};
  assign diff   = rem_sh[DIV_W-1:0] - dvs;
  assign sr_nxt = ge ? {diff, sr[DIV_W-2:0], 1'b1} : {sr[2*DIV_W-2:0], 1'b0};
endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit restoring divider with stream handshakes and held result.
// Optional feature macro: DIV_EARLY_OUT_EN (skip iterations for trivial divides).
module div_unit
  import div_pkg::*;
#(
  parameter bit SIGNED = 1'b1
) (
  input logic clk,
  input logic reset,
  div_if.slave axis
);
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_PREP = PREP;
  localparam logic [1:0] ST_CALC = CALC;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]         state;
  logic               armed, dvd_full, dvs_full;
  logic [DIV_W-1:0]   dvd_q, dvs_q, dvs_mag;
  logic [2*DIV_W-1:0] sr, sr_nxt, dout;
  logic [4:0]         cnt;
  logic               sign_q, sign_r, dout_vld;

  logic dvd_rdy, dvs_rdy, dvd_fire, dvs_fire, dvd_neg, dvs_neg, dvs_zero;
  logic [DIV_W-1:0] dvd_mag_c, dvs_mag_c;

  // armed keeps the treadys low through reset without a reset-to-output path.
  assign dvd_rdy  = armed && (state == ST_IDLE) && !dvd_full;
  assign dvs_rdy  = armed && (state == ST_IDLE) && !dvs_full;
  assign dvd_fire = axis.s_axis_dividend_tvalid && dvd_rdy;
  assign dvs_fire = axis.s_axis_divisor_tvalid && dvs_rdy;

  assign dvd_neg   = SIGNED && dvd_q[DIV_W-1];
  assign dvs_neg   = SIGNED && dvs_q[DIV_W-1];
  assign dvd_mag_c = dvd_neg ? -dvd_q : dvd_q;
  assign dvs_mag_c = dvs_neg ? -dvs_q : dvs_q;
  assign dvs_zero  = (dvs_q == '0);

  div_step u_step (.sr(sr), .dvs(dvs_mag), .sr_nxt(sr_nxt));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      armed    <= 1'b0;
      dvd_full <= 1'b0;
      dvs_full <= 1'b0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      dvs_mag  <= '0;
      sr       <= '0;
      cnt      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      dout     <= '0;
      dout_vld <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (dvd_fire) begin
            dvd_q    <= axis.s_axis_dividend_tdata;
            dvd_full <= 1'b1;
          end
          if (dvs_fire) begin
            dvs_q    <= axis.s_axis_divisor_tdata;
            dvs_full <= 1'b1;
          end
          if ((dvd_full || dvd_fire) && (dvs_full || dvs_fire)) state <= ST_PREP;
        end
        ST_PREP: begin
          sr      <= {{DIV_W{1'b0}}, dvd_mag_c};
          dvs_mag <= dvs_mag_c;
          cnt     <= '0;
          sign_q  <= dvd_neg ^ dvs_neg;
          sign_r  <= dvd_neg;
`ifdef DIV_EARLY_OUT_EN
          if (dvs_zero || (dvd_mag_c < dvs_mag_c)) begin
            dout     <= dvs_zero ? {dvd_q, DIV_ZERO_Q} : {dvd_q, {DIV_W{1'b0}}};
            dout_vld <= 1'b1;
            state    <= ST_DONE;
          end else begin
            state <= ST_CALC;
          end
`else
          state <= ST_CALC;
`endif
        end
        ST_CALC: begin
          sr  <= sr_nxt;
          cnt <= cnt + 5'd1;
          if (cnt == 5'(DIV_ITER - 1)) begin
            // Divide-by-zero bypasses the sign fix: raw dividend, all-ones quotient.
            dout     <= dvs_zero ? {dvd_q, DIV_ZERO_Q} : apply_sign(sr_nxt, sign_q, sign_r);
            dout_vld <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (axis.m_axis_dout_tready) begin
            dout_vld <= 1'b0;
            dvd_full <= 1'b0;
            dvs_full <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign axis.s_axis_dividend_tready = dvd_rdy;
  assign axis.s_axis_divisor_tready  = dvs_rdy;
  assign axis.m_axis_dout_tdata      = dout;
  assign axis.m_axis_dout_tvalid     = dout_vld;
endmodule
